draw_rot_sprite: RTL and testbench
==================================

Name: draw_rot_sprite

Overview:
Parametrised sprite blitter for rotating game objects (ship, later asteroids/UFO). It scans an S×S sprite frame out of one shared external frame ROM, one pixel per clock. Optional X/Y mirroring lets one quadrant of artwork serve all four. It emits pixel writes for the VGA adapter, skips transparent pixels and clips against the screen. It sits between object-control FSMs (which choose frame and mirror bits from direction) and the VGA write arbiter.

Parameters:
SPRITE_SIZE, 32, sprite side length in pixels; power of two, 4..64
FRAMES, 24, number of frames stored back-to-back in the ROM
COLOR_W, 3, pixel colour width
TRANSPARENT, 0, colour value treated as transparent (no write)
FRAME_W, 5, width of frame select; at least ceil(log2(FRAMES))
ADDR_W, 15, ROM address width; at least ceil(log2(FRAMES*SPRITE_SIZE^2))
SCREEN_W, 320, visible width; pixels with x >= SCREEN_W are clipped
SCREEN_H, 240, visible height; pixels with y >= SCREEN_H are clipped

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
plot  in  1  start request; sampled only in IDLE
x_pos  in  10  sprite top-left x; latched on accept
y_pos  in  10  sprite top-left y; latched on accept
frame  in  FRAME_W  frame index; latched on accept
flip_x  in  1  mirror horizontally; latched on accept
flip_y  in  1  mirror vertically; latched on accept
rom_addr  out  ADDR_W  registered ROM address
rom_data  in  COLOR_W  synchronous ROM output, valid 1 clk after rom_addr
x  out  10  pixel x
y  out  10  pixel y
color  out  COLOR_W  pixel colour
writeEn  out  1  pixel write strobe
busy  out  1  high whenever state != IDLE
draw_done  out  1  one-cycle pulse with the last pixel slot

Behaviour:
- Reset (async, reset_n=0): state IDLE. Outputs rom_addr, x, y, color, writeEn, busy and draw_done are all 0. Counters and latches are cleared. An in-flight draw is abandoned and no draw_done is produced.
- States: IDLE, SCAN, DRAIN.
- IDLE: at an edge with plot=1, latch x_pos, y_pos, frame, flip_x and flip_y. Clear cx and cy. Set rom_addr to the pixel (0,0) address and go to SCAN.
- Out-of-range frame: if frame >= FRAMES, latch frame 0.
- Address: rom_addr = f*S*S + sy*S + sx, where S = SPRITE_SIZE.
  - sx = flip_x ? S-1-cx : cx
  - sy = flip_y ? S-1-cy : cy
  - Use shifts only; no multiplier for S*S or sy*S.
- SCAN: on each edge, cx increments. When cx wraps from S-1 to 0, cy increments. One address is issued per cycle, in raster order (cx fastest).
  - After the edge that issues (S-1,S-1), go to DRAIN.
- Pipeline (two stages):
  - Stage 1 carries cx, cy and a valid bit alongside the ROM access.
  - Stage 2 registers the outputs: x = x0+cx and y = y0+cy (10-bit, mod 1024), color = rom_data.
  - writeEn = valid AND rom_data != TRANSPARENT AND x < SCREEN_W AND y < SCREEN_H.
  - color and x/y still update when writeEn=0.
- Latency: plot accepted at edge E0 puts pixel (0,0) on the outputs after E2. Pixel k appears after edge E(k+2). The last pixel appears after E(S*S+1).
- DRAIN: lasts until the last pixel is loaded into stage 2. At that same edge draw_done goes to 1 for exactly one cycle and the state goes to IDLE.
- busy: 1 from E0 up to, but not including, the draw_done cycle.
- Back-to-back draws: plot=1 during the draw_done cycle is accepted. The next address stream then starts with no gap.
- plot while busy: ignored, not queued. Changes to x_pos, y_pos, frame or flip bits during a draw have no effect.
- Outputs outside valid pixel slots: writeEn=0.

Test Plan:
- Bench uses SPRITE_SIZE=4, FRAMES=4.
  - ROM word = address mod 8, with TRANSPARENT=0.
  - frame=2, x_pos=10, y_pos=20, plot pulse at E0.
  - Expected: rom_addr sequence 32..47.
  - First output after E2 is (10,20), color 0, writeEn=0. Next is (11,20), color 1, writeEn=1.
  - draw_done appears exactly once, after E17. busy is high for 17 cycles.
- Same draw with flip_x=1, flip_y=1:
  - Expected: rom_addr sequence 47 down to 32, with output coordinates still in raster order.
- x_pos=318, y_pos=238:
  - Expected: writeEn only for x in {318,319} and y in {238,239}, and only for non-zero colour.
  - Clipped slots still advance and draw_done timing is unchanged.
- frame=7 (>= FRAMES):
  - Expected: addresses 0..15.
- plot held high continuously:
  - Expected: second draw's first rom_addr appears in the cycle after the first draw's draw_done. Exactly two draw_done pulses in 36 cycles.
  - A plot pulse mid-draw adds nothing.
- reset_n low at the 6th SCAN cycle:
  - Expected: all outputs 0 immediately (asynchronously), no draw_done.
  - After release, a new plot starts cleanly at pixel (0,0).

Source files
------------

// File: rtl/draw_rot_sprite.sv
// draw_rot_sprite
//   Rotating-object sprite blitter. Scans an S x S frame out of a shared
//   synchronous frame ROM at one pixel per clock. It can mirror the frame in
//   X and/or Y, skips transparent pixels, clips against the screen and emits
//   VGA pixel writes.
//
//   Ports
//     clk, reset_n       clock, asynchronous active-low reset
//     plot               start request, sampled only while idle
//     x_pos, y_pos       sprite top-left corner, latched on accept
//     frame              frame index (>= FRAMES selects frame 0), latched
//     flip_x, flip_y     horizontal / vertical mirror, latched
//     rom_addr/rom_data  ROM port; data is valid one clock after the address
//     x, y, color        pixel write coordinates and colour
//     writeEn            pixel write strobe
//     busy               high while a draw is in progress
//     draw_done          one-cycle pulse alongside the last pixel slot
module draw_rot_sprite #(
   parameter int                   SPRITE_SIZE = 32,
   parameter int                   FRAMES      = 24,
   parameter int                   COLOR_W     = 3,
   parameter logic [COLOR_W-1:0]   TRANSPARENT = '0,
   parameter int                   FRAME_W     = 5,
   parameter int                   ADDR_W      = 15,
   parameter int                   SCREEN_W    = 320,
   parameter int                   SCREEN_H    = 240
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               plot,
   input  logic [9:0]         x_pos,
   input  logic [9:0]         y_pos,
   input  logic [FRAME_W-1:0] frame,
   input  logic               flip_x,
   input  logic               flip_y,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [COLOR_W-1:0] rom_data,
   output logic [9:0]         x,
   output logic [9:0]         y,
   output logic [COLOR_W-1:0] color,
   output logic               writeEn,
   output logic               busy,
   output logic               draw_done
);

   localparam int LOG_S  = $clog2(SPRITE_SIZE);
   localparam int STAGES = 1;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t              state;
   logic [9:0]          x0, y0;
   logic [FRAME_W-1:0]  f_lat;
   logic                fx_lat, fy_lat;
   logic [LOG_S-1:0]    cx, cy;        // pixel whose address is on rom_addr
   logic [LOG_S-1:0]    s1_cx, s1_cy;  // pixel whose data is on rom_data
   // [0]: rom_addr holds a live pixel, [1]: rom_data holds a live pixel
   logic [STAGES:0]     vld_pipe;

   logic [LOG_S-1:0]    cx_nx, cy_nx;
   logic [FRAME_W-1:0]  frame_ok;
   logic [9:0]          xs, ys;

   // Mirroring S-1-c is a bitwise invert because S is a power of two; the
   // frame and row offsets are shifts, so no multiplier is inferred.
   function automatic logic [ADDR_W-1:0] pix_addr(
      input logic [FRAME_W-1:0] f,
      input logic               fx,
      input logic               fy,
      input logic [LOG_S-1:0]   px,
      input logic [LOG_S-1:0]   py
   );
      logic [LOG_S-1:0] sx, sy;
      sx = fx ? ~px : px;
      sy = fy ? ~py : py;
      return (ADDR_W'(f) << (2 * LOG_S)) | (ADDR_W'(sy) << LOG_S) | ADDR_W'(sx);
   endfunction

   always_comb begin
      cx_nx    = cx + LOG_S'(1);
      cy_nx    = (cx == '1) ? cy + LOG_S'(1) : cy;
      frame_ok = (32'(frame) < FRAMES) ? frame : '0;
      xs       = x0 + 10'(s1_cx);
      ys       = y0 + 10'(s1_cy);
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         x0        <= '0;
         y0        <= '0;
         f_lat     <= '0;
         fx_lat    <= 1'b0;
         fy_lat    <= 1'b0;
         cx        <= '0;
         cy        <= '0;
         s1_cx     <= '0;
         s1_cy     <= '0;
         vld_pipe  <= '0;
         rom_addr  <= '0;
         x         <= '0;
         y         <= '0;
         color     <= '0;
         writeEn   <= 1'b0;
         draw_done <= 1'b0;
      end else begin
         // stage 1: coordinates follow the ROM access by one clock
         vld_pipe[1] <= vld_pipe[0];
         s1_cx       <= cx;
         s1_cy       <= cy;

         // stage 2: registered pixel outputs; x/y/colour update every slot
         x       <= xs;
         y       <= ys;
         color   <= rom_data;
         writeEn <= vld_pipe[1] && (rom_data != TRANSPARENT) &&
                    (32'(xs) < SCREEN_W) && (32'(ys) < SCREEN_H);

         draw_done <= 1'b0;

         case (state)
            IDLE: begin
               vld_pipe[0] <= 1'b0;
               if (plot) begin
                  x0          <= x_pos;
                  y0          <= y_pos;
                  f_lat       <= frame_ok;
                  fx_lat      <= flip_x;
                  fy_lat      <= flip_y;
                  cx          <= '0;
                  cy          <= '0;
                  rom_addr    <= pix_addr(frame_ok, flip_x, flip_y, '0, '0);
                  vld_pipe[0] <= 1'b1;
                  state       <= SCAN;
               end
            end
            SCAN: begin
               cx       <= cx_nx;
               cy       <= cy_nx;
               rom_addr <= pix_addr(f_lat, fx_lat, fy_lat, cx_nx, cy_nx);
               if (cx_nx == '1 && cy_nx == '1)
                  state <= DRAIN;
            end
            DRAIN: begin
               // First DRAIN edge moves the last address into stage 1; the
               // next one loads it into stage 2, which is the done slot.
               vld_pipe[0] <= 1'b0;
               if (!vld_pipe[0]) begin
                  draw_done <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_rot_sprite.sv
module tb_draw_rot_sprite;

   localparam int S      = 4;
   localparam int FRAMES = 4;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       plot = 1'b0;
   logic [9:0] x_pos = '0, y_pos = '0;
   logic [2:0] frame = '0;
   logic       flip_x = 1'b0, flip_y = 1'b0;
   logic [5:0] rom_addr;
   logic [2:0] rom_data = '0;
   logic [9:0] x, y;
   logic [2:0] color;
   logic       writeEn, busy, draw_done;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   pix_t pix_q[$];
   int   done_q[$];
   int   exp_addr[16];
   pix_t first_pix;
   bit   first_we;
   pix_t mp;
   int   md;

   draw_rot_sprite #(
      .SPRITE_SIZE(S), .FRAMES(FRAMES), .COLOR_W(3), .TRANSPARENT(3'd0),
      .FRAME_W(3), .ADDR_W(6), .SCREEN_W(320), .SCREEN_H(240)
   ) dut (
      .clk(clk), .reset_n(reset_n), .plot(plot), .x_pos(x_pos), .y_pos(y_pos),
      .frame(frame), .flip_x(flip_x), .flip_y(flip_y), .rom_addr(rom_addr),
      .rom_data(rom_data), .x(x), .y(y), .color(color), .writeEn(writeEn),
      .busy(busy), .draw_done(draw_done)
   );

   always #5 clk = ~clk;

   // synchronous ROM: word = address mod 8
   always @(posedge clk) rom_data <= rom_addr[2:0];
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard monitor: pixel writes and draw_done pulses
   always @(negedge clk) begin
      if (reset_n) begin
         if (writeEn) begin
            if (pix_q.size() == 0)
               chk(1'b0, "unexpected_write", {x, y, color}, 0);
            else begin
               mp = pix_q.pop_front();
               chk({x, y, color} == mp, "pixel_write", {x, y, color}, mp);
            end
         end
         if (draw_done) begin
            if (done_q.size() == 0)
               chk(1'b0, "unexpected_done", cyc, -1);
            else begin
               md = done_q.pop_front();
               chk(cyc == md, "done_cycle", cyc, md);
            end
         end
      end
   end

   // Reference model: raster walk over the sprite, build expected addresses
   // and the visible non-transparent writes.
   task automatic model(input int xp, input int yp, input int fr, input bit fx, input bit fy);
      int fe, cx, cy, sx, sy, a, px, py;
      pix_t p;
      fe = (fr < FRAMES) ? fr : 0;
      for (int k = 0; k < S * S; k++) begin
         cx = k % S;
         cy = k / S;
         sx = fx ? S - 1 - cx : cx;
         sy = fy ? S - 1 - cy : cy;
         a  = fe * S * S + sy * S + sx;
         px = (xp + cx) % 1024;
         py = (yp + cy) % 1024;
         exp_addr[k] = a;
         p.x = 10'(px);
         p.y = 10'(py);
         p.c = 3'(a % 8);
         if (k == 0) begin
            first_pix = p;
            first_we  = (a % 8 != 0) && px < 320 && py < 240;
         end
         if ((a % 8 != 0) && px < 320 && py < 240) pix_q.push_back(p);
      end
   endtask

   // Called at posedge+1 with the DUT idle (or with plot already held).
   task automatic draw(input int xp, input int yp, input int fr, input bit fx,
                       input bit fy, input bit keep);
      int e0;
      model(xp, yp, fr, fx, fy);
      x_pos = 10'(xp); y_pos = 10'(yp); frame = 3'(fr);
      flip_x = fx; flip_y = fy; plot = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      done_q.push_back(e0 + S * S + 1);
      if (!keep) plot = 1'b0;
      chk(rom_addr == 6'(exp_addr[0]), "addr0", rom_addr, exp_addr[0]);
      chk(busy == 1'b1, "busy_start", busy, 1);
      for (int k = 1; k <= S * S + 1; k++) begin
         if (!keep) begin
            // inputs and a stray plot during the draw must be ignored
            x_pos = 10'($urandom); y_pos = 10'($urandom); frame = 3'($urandom);
            flip_x = 1'($urandom); flip_y = 1'($urandom);
            plot = (k == 5);
         end
         @(posedge clk); #1;
         if (k < S * S)
            chk(rom_addr == 6'(exp_addr[k]), "addr_seq", rom_addr, exp_addr[k]);
         if (k == 2) begin
            chk({x, y, color} == first_pix, "first_pix", {x, y, color}, first_pix);
            chk(writeEn == first_we, "first_we", writeEn, first_we);
         end
         chk(busy == (k < S * S + 1), "busy", busy, k < S * S + 1);
      end
      if (!keep) plot = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk(rom_addr == 0, "rst_addr", rom_addr, 0);
      chk(x == 0, "rst_x", x, 0);
      chk(y == 0, "rst_y", y, 0);
      chk(color == 0, "rst_color", color, 0);
      chk(writeEn == 0, "rst_we", writeEn, 0);
      chk(busy == 0, "rst_busy", busy, 0);
      chk(draw_done == 0, "rst_done", draw_done, 0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;

      draw(10, 20, 2, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      draw(10, 20, 2, 1, 1, 0);
      @(posedge clk); #1;
      draw(318, 238, 1, 0, 0, 0);
      @(posedge clk); #1;
      draw(50, 60, 7, 0, 0, 0);
      @(posedge clk); #1;

      // plot held: second draw starts the cycle after draw_done
      draw(100, 100, 3, 0, 1, 1);
      draw(5, 5, 1, 1, 0, 0);
      @(posedge clk); #1;

      // reset in the 6th SCAN cycle of a fully clipped draw
      x_pos = 10'd400; y_pos = 10'd0; frame = 3'd1; plot = 1'b1;
      @(posedge clk); #1;
      plot = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk(rom_addr == 0, "arst_addr", rom_addr, 0);
      chk({x, y, color} == 0, "arst_pix", {x, y, color}, 0);
      chk(writeEn == 0, "arst_we", writeEn, 0);
      chk(busy == 0, "arst_busy", busy, 0);
      chk(draw_done == 0, "arst_done", draw_done, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk(draw_done == 0 && busy == 0, "post_rst_idle", {draw_done, busy}, 0);
      end
      draw(10, 20, 2, 0, 0, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         int xp, yp;
         case ($urandom_range(0, 2))
            0: xp = $urandom_range(0, 400);
            1: xp = $urandom_range(310, 325);
            default: xp = $urandom_range(1018, 1023);
         endcase
         case ($urandom_range(0, 2))
            0: yp = $urandom_range(0, 300);
            1: yp = $urandom_range(230, 245);
            default: yp = $urandom_range(1018, 1023);
         endcase
         draw(xp, yp, $urandom_range(0, 7), 1'($urandom), 1'($urandom), 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      #1;
      chk(pix_q.size() == 0, "pix_q_empty", pix_q.size(), 0);
      chk(done_q.size() == 0, "done_q_empty", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
